// File: rtl/tdm_demux_if.sv
// tdm_demux_if: bundles the multiplexed input stream and the demultiplexed lane
// outputs of tdm_demux.
//   master : the stream source / lane consumer (drives din, din_valid, frame_sync)
//   slave  : the demultiplexer (drives dout, dout_valid, sel, locked,
//            frame_done, sync_err)
interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      frame_sync;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS-1:0]       dout_valid;
  logic [SEL_W-1:0]          sel;
  logic                      locked;
  logic                      frame_done;
  logic                      sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, sel, locked, frame_done, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, sel, locked, frame_done, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: distributes one shared sample stream round-robin into CHANNELS
// registered output lanes, aligned by frame_sync.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - tdm_demux_if.slave:
//            din/din_valid/frame_sync in; dout (lane k at [k*WIDTH +: WIDTH]),
//            dout_valid (one-hot strobe), sel (next lane), locked (RUN),
//            frame_done (last lane written), sync_err (misaligned sync) out.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(CHANNELS - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
  logic [CHANNELS-1:0]       dout_valid_q, dout_valid_d;
  logic                      frame_done_q, frame_done_d;
  logic                      sync_err_q, sync_err_d;

  logic                      wr_en;
  logic [SEL_W-1:0]          wr_lane;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      sel_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    dout_d       = dout_q;
    dout_valid_d = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    wr_en        = 1'b0;
    wr_lane      = '0;

    // frame_sync only means something on a valid sample.
    if (bus.din_valid) begin
      if (state_q == HUNT) begin
        // Samples before the first frame marker have no known lane; drop them.
        if (bus.frame_sync) begin
          wr_en   = 1'b1;
          state_d = RUN;
          sel_d   = SEL_W'(1);
        end
      end else if (bus.frame_sync) begin
        // A marker anywhere but lane 0 abandons the partial frame.
        wr_en      = 1'b1;
        sel_d      = SEL_W'(1);
        sync_err_d = (sel_q != '0);
      end else begin
        wr_en   = 1'b1;
        wr_lane = sel_q;
        // Explicit wrap so non-power-of-two CHANNELS never reach unused codes.
        if (sel_q == LAST_LANE) begin
          sel_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end
    end

    for (int k = 0; k < CHANNELS; k++) begin
      if (wr_en && (wr_lane == SEL_W'(k))) begin
        dout_d[k*WIDTH +: WIDTH] = bus.din;
        dout_valid_d[k]          = 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sel        = sel_q;
  assign bus.locked     = (state_q == RUN);
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: drives a 4-lane and a 3-lane tdm_demux and compares every
// cycle against a lane/frame-level reference model.
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tdm_demux_if #(.CHANNELS(4), .WIDTH(8)) if4();
  tdm_demux_if #(.CHANNELS(3), .WIDTH(8)) if3();

  tdm_demux #(.CHANNELS(4), .WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  tdm_demux #(.CHANNELS(3), .WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  int checks   = 0;
  int failures = 0;

  // Reference model, index 0 = 4-lane DUT, index 1 = 3-lane DUT.
  logic [7:0]  m_lane   [2][16];
  int          m_nxt    [2];
  bit          m_locked [2];
  logic [15:0] m_dv     [2];
  bit          m_fd     [2];
  bit          m_se     [2];

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      for (int k = 0; k < 16; k++) m_lane[id][k] = 8'h00;
      m_nxt[id] = 0; m_locked[id] = 0; m_dv[id] = '0; m_fd[id] = 0; m_se[id] = 0;
    end
  endtask

  // Frame-level behaviour: a sample goes to lane 0 on a marker, otherwise to the
  // next lane of the frame; the frame ends when the last lane is filled.
  task automatic model_step(input int id, input int nch, input bit v, input bit fs,
                            input logic [7:0] d);
    m_dv[id] = '0; m_fd[id] = 0; m_se[id] = 0;
    if (!v) return;
    if (fs) begin
      m_se[id]     = m_locked[id] && (m_nxt[id] != 0);
      m_lane[id][0] = d;
      m_dv[id]     = 16'h0001;
      m_nxt[id]    = 1;
      m_locked[id] = 1;
    end else if (m_locked[id]) begin
      m_lane[id][m_nxt[id]] = d;
      m_dv[id]  = 16'h0001 << m_nxt[id];
      m_nxt[id] = (m_nxt[id] + 1) % nch;
      m_fd[id]  = (m_nxt[id] == 0);
    end
  endtask

  function automatic logic [40:0] exp4();
    logic [31:0] dd;
    for (int k = 0; k < 4; k++) dd[k*8 +: 8] = m_lane[0][k];
    return {dd, m_dv[0][3:0], 2'(m_nxt[0]), m_locked[0], m_fd[0], m_se[0]};
  endfunction

  function automatic logic [31:0] exp3();
    logic [23:0] dd;
    for (int k = 0; k < 3; k++) dd[k*8 +: 8] = m_lane[1][k];
    return {dd, m_dv[1][2:0], 2'(m_nxt[1]), m_locked[1], m_fd[1], m_se[1]};
  endfunction

  function automatic logic [40:0] got4();
    return {if4.dout, if4.dout_valid, if4.sel, if4.locked, if4.frame_done, if4.sync_err};
  endfunction

  function automatic logic [31:0] got3();
    return {if3.dout, if3.dout_valid, if3.sel, if3.locked, if3.frame_done, if3.sync_err};
  endfunction

  // Drive at the falling edge, advance the model at the rising edge, return at
  // the next falling edge where outputs are sampled.
  task automatic tick4(input bit v, input bit fs, input logic [7:0] d);
    if4.din_valid = v; if4.frame_sync = fs; if4.din = d;
    if3.din_valid = 0; if3.frame_sync = 0; if3.din = 8'h00;
    @(posedge clk);
    model_step(0, 4, v, fs, d);
    model_step(1, 3, 0, 0, 8'h00);
    @(negedge clk);
  endtask

  task automatic tick3(input bit v, input bit fs, input logic [7:0] d);
    if3.din_valid = v; if3.frame_sync = fs; if3.din = d;
    if4.din_valid = 0; if4.frame_sync = 0; if4.din = 8'h00;
    @(posedge clk);
    model_step(1, 3, v, fs, d);
    model_step(0, 4, 0, 0, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset();
    if4.din_valid = 0; if4.frame_sync = 0; if4.din = 8'h00;
    if3.din_valid = 0; if3.frame_sync = 0; if3.din = 8'h00;
    rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (got4() !== exp4()) begin
      failures++; $display("FAIL reset4 got=%h exp=%h", got4(), exp4());
    end
    checks++;
    if (got3() !== exp3()) begin
      failures++; $display("FAIL reset3 got=%h exp=%h", got3(), exp3());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_hunt();
    logic [7:0] data [3] = '{8'h11, 8'h22, 8'hA0};
    for (int i = 0; i < 3; i++) begin
      tick4(1'b1, i == 2, data[i]);
      checks++;
      if (got4() !== exp4()) begin
        failures++; $display("FAIL hunt[%0d] got=%h exp=%h", i, got4(), exp4());
      end
    end
    checks++;
    if (if4.dout !== 32'h000000A0 || if4.dout_valid !== 4'b0001 || if4.sel !== 2'd1
        || if4.locked !== 1'b1) begin
      failures++;
      $display("FAIL hunt_lock dout=%h dv=%b sel=%0d locked=%b exp dout=000000a0 dv=0001 sel=1 locked=1",
               if4.dout, if4.dout_valid, if4.sel, if4.locked);
    end
  endtask

  task automatic test_full_frame();
    for (int i = 1; i < 4; i++) begin
      tick4(1'b1, 1'b0, 8'hA0 + 8'(i));
      checks++;
      if (got4() !== exp4()) begin
        failures++; $display("FAIL frame[%0d] got=%h exp=%h", i, got4(), exp4());
      end
    end
    checks++;
    if (if4.dout !== 32'hA3A2A1A0 || if4.dout_valid !== 4'b1000 || if4.frame_done !== 1'b1
        || if4.sel !== 2'd0) begin
      failures++;
      $display("FAIL frame_end dout=%h dv=%b fd=%b sel=%0d exp dout=a3a2a1a0 dv=1000 fd=1 sel=0",
               if4.dout, if4.dout_valid, if4.frame_done, if4.sel);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 4; i++) begin
      tick4(1'b1, i == 0, 8'hD0 + 8'(i));
      checks++;
      if (got4() !== exp4()) begin
        failures++; $display("FAIL gap_sample[%0d] got=%h exp=%h", i, got4(), exp4());
      end
      for (int g = 0; g < 3; g++) begin
        tick4(1'b0, (g == 1), 8'hEE);
        checks++;
        if (got4() !== exp4()) begin
          failures++; $display("FAIL gap_idle[%0d.%0d] got=%h exp=%h", i, g, got4(), exp4());
        end
      end
    end
  endtask

  task automatic test_resync();
    tick4(1'b1, 1'b1, 8'hE0);
    tick4(1'b1, 1'b0, 8'hE1);
    checks++;
    if (got4() !== exp4()) begin
      failures++; $display("FAIL resync_pre got=%h exp=%h", got4(), exp4());
    end
    tick4(1'b1, 1'b1, 8'hB0);
    checks++;
    if (got4() !== exp4()) begin
      failures++; $display("FAIL resync got=%h exp=%h", got4(), exp4());
    end
    checks++;
    if (if4.dout !== 32'hD3D2E1B0 || if4.sync_err !== 1'b1 || if4.frame_done !== 1'b0
        || if4.sel !== 2'd1) begin
      failures++;
      $display("FAIL resync_lanes dout=%h se=%b fd=%b sel=%0d exp dout=d3d2e1b0 se=1 fd=0 sel=1",
               if4.dout, if4.sync_err, if4.frame_done, if4.sel);
    end
  endtask

  task automatic test_reset_midrun();
    tick4(1'b1, 1'b0, 8'hB1);
    checks++;
    if (if4.sel !== 2'd2) begin
      failures++; $display("FAIL midrun_sel got=%0d exp=2", if4.sel);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got4() !== exp4() || got4() !== 41'd0) begin
      failures++; $display("FAIL midrun_reset got=%h exp=%h", got4(), exp4());
    end
    @(negedge clk);
    rst = 1'b0;
    tick4(1'b1, 1'b0, 8'h55);
    checks++;
    if (got4() !== exp4()) begin
      failures++; $display("FAIL post_reset_hunt got=%h exp=%h", got4(), exp4());
    end
  endtask

  task automatic test_ch3();
    logic [1:0] sel_seq [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      tick3(1'b1, i == 0, 8'(i + 1));
      checks++;
      if (got3() !== exp3() || if3.sel !== sel_seq[i] || if3.frame_done !== (i == 2)) begin
        failures++;
        $display("FAIL ch3[%0d] got=%h exp=%h sel=%0d exp_sel=%0d",
                 i, got3(), exp3(), if3.sel, sel_seq[i]);
      end
    end
    checks++;
    if (if3.dout !== 24'h030204) begin
      failures++; $display("FAIL ch3_lanes got=%h exp=030204", if3.dout);
    end
  endtask

  task automatic test_random();
    bit v, fs;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      fs = ($urandom_range(0, 9) < 2);
      d  = 8'($urandom);
      if (i[0]) begin
        tick3(v, fs, d);
        checks++;
        if (got3() !== exp3()) begin
          failures++; $display("FAIL rand3[%0d] got=%h exp=%h", i, got3(), exp3());
        end
      end else begin
        tick4(v, fs, d);
        checks++;
        if (got4() !== exp4()) begin
          failures++; $display("FAIL rand4[%0d] got=%h exp=%h", i, got4(), exp4());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hunt();
    test_full_frame();
    test_gaps();
    test_resync();
    test_reset_midrun();
    test_ch3();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: one shared sample stream is distributed round-robin into CHANNELS registered output lanes.
- Receive-side counterpart of the 2:1 selector datapath. A channel-select counter, driven by frame alignment, replaces the static select input.
- Sits after a TDM link or serializer and feeds per-channel consumers. Each consumer sees its own held sample and a one-cycle update strobe.

Parameters:
- CHANNELS, 4, number of output lanes; legal range 2..16.
- WIDTH, 8, bits per sample.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  WIDTH  incoming multiplexed sample.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the sample as channel 0 of a frame.
- dout  output  CHANNELS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]; each lane holds its last sample.
- dout_valid  output  CHANNELS  one-hot, one-cycle strobe per lane update.
- sel  output  $clog2(CHANNELS)  index of the lane the next sample will go to.
- locked  output  1  high in RUN state.
- frame_done  output  1  one-cycle pulse when the last lane of a frame is written.
- sync_err  output  1  one-cycle pulse on a misaligned frame_sync.

Behaviour:
- Reset (asynchronous assert, any time, including mid-frame):
  - dout=0, dout_valid=0, sel=0, locked=0, frame_done=0, sync_err=0.
  - State=HUNT.
- States: HUNT, RUN.
- HUNT:
  - din_valid=1, frame_sync=0: sample dropped; no strobes.
  - din_valid=1, frame_sync=1: din written to lane 0; sel<=1; state<=RUN.
  - frame_sync with din_valid=0 is ignored in every state.
- RUN, din_valid=1, frame_sync=0: din written to lane sel; sel<=sel+1.
  - When sel==CHANNELS-1, sel wraps to 0 and frame_done pulses.
- RUN, din_valid=1, frame_sync=1, sel==0: normal frame start; din written to lane 0; sel<=1.
- RUN, din_valid=1, frame_sync=1, sel!=0 (resync):
  - din written to lane 0; sel<=1; sync_err pulses; state stays RUN.
  - The partial frame is abandoned: no frame_done, and lanes not yet written keep their old values.
- RUN, din_valid=0: no change; gaps of any length are allowed between samples.
- Latency: sample accepted at edge N appears on its dout lane after edge N. Its dout_valid bit, frame_done and sync_err are high for exactly the cycle following edge N, i.e. the same cycle the new data is visible.
- dout_valid is never multi-hot. All strobes deassert the next cycle unless another valid sample arrives.
- Back-to-back samples (din_valid held high) are accepted every cycle; no stall, no backpressure.
- Lanes not being written hold their value indefinitely.
- sel is registered and always reflects the destination of the next accepted sample. It stays 0 in HUNT.
- CHANNELS not a power of two (e.g. 3): sel wraps explicitly at CHANNELS-1 and never reaches unused codes.
- locked stays 1 after entering RUN until rst. There is no loss-of-lock timeout.

Test Plan:
- Reset: rst=1 mid-run with sel=2 -> all outputs 0 immediately (before next clk edge); HUNT, locked=0.
- Hunt: CHANNELS=4; samples 0x11,0x22 without sync, then 0xA0 with sync -> first two dropped, no strobes; lane0=0xA0, dout_valid=0001, sel=1, locked=1.
- Full frame, back-to-back: after the sync sample, 0xA1,0xA2,0xA3 on consecutive cycles -> lanes1..3 = 0xA1..0xA3; dout_valid 0010,0100,1000; frame_done with 1000; sel=0.
- Gaps: the same frame with 3 idle cycles between each sample -> identical lane values; strobes only on the cycles after accepted samples; sel unchanged during gaps.
- Resync: sel=2, then 0xB0 with frame_sync -> lane0=0xB0, sync_err=1, no frame_done, lanes2/3 unchanged, sel=1.
- CHANNELS=3: frames 0x01,0x02,0x03 then 0x04 without sync -> frame_done after 0x03; 0x04 written to lane 0; sel sequence 1,2,0,1.
